// File: rtl/stall_ctrl_pkg.sv
// Shared stall-bus encodings, FSM states and helpers for the pipeline stall controller.
package stall_ctrl_pkg;

  localparam int   STALL_BUS = 4;
  localparam logic STOP      = 1'b1;
  localparam logic NOSTOP    = 1'b0;

  typedef logic [STALL_BUS-1:0] stall_t;

  // Bit order: [3] EXE/MEM, [2] ID/EXE, [1] IF/ID, [0] PC
  localparam stall_t STALL_NONE    = {4{NOSTOP}};
  localparam stall_t STALL_LOADUSE = {NOSTOP, STOP, STOP, STOP};
  localparam stall_t STALL_DIV     = {4{STOP}};

  typedef enum logic {
    IDLE    = 1'b0,
    DIV_RUN = 1'b1
  } state_e;

  function automatic stall_t id_stall(input logic req);
    return req ? STALL_LOADUSE : STALL_NONE;
  endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// Request/response bundle between the pipeline stages, the divider and the stall controller.
interface stall_ctrl_if
  import stall_ctrl_pkg::*;
#(
  parameter int STALL_W = STALL_BUS,
  parameter int CNT_W   = 32
);
  logic               stallreq_id;
  logic               exe_div_req;
  logic               div_ready;
  logic               flush_req;
  logic [STALL_W-1:0] stall;
  logic               div_start;
  logic               div_cancel;
  logic               flush;
  logic               div_timeout;
  logic [CNT_W-1:0]   stall_cycles;

  modport master (
    output stallreq_id, exe_div_req, div_ready, flush_req,
    input  stall, div_start, div_cancel, flush, div_timeout, stall_cycles
  );

  modport slave (
    input  stallreq_id, exe_div_req, div_ready, flush_req,
    output stall, div_start, div_cancel, flush, div_timeout, stall_cycles
  );
endinterface

// File: rtl/stall_ctrl_sat_counter.sv
// Saturating up-counter: counts enabled cycles and holds at all-ones instead of wrapping.
module stall_ctrl_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: merges load-use and divider stalls, sequences the divider
// handshake and aborts divides on exception or timeout. Stall outputs are combinational.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int STALL_W     = STALL_BUS,
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  stall_ctrl_if.slave bus
);

  localparam int                DCNT_W    = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DIV_TIMEOUT - 1);

  state_e            state;
  state_e            state_nxt;
  logic [DCNT_W-1:0] div_cnt;
  stall_t            stall_nxt;
  logic              start;
  logic              cancel;
  logic              cnt_inc;
  logic              timeout_hit;
  logic              timeout_flag;

  // Outputs are held at their idle values while reset is asserted so the divider,
  // which shares this reset, never sees a start or cancel pulse during reset.
  always_comb begin
    state_nxt   = state;
    stall_nxt   = STALL_NONE;
    start       = 1'b0;
    cancel      = 1'b0;
    cnt_inc     = 1'b0;
    timeout_hit = 1'b0;
    if (cpu_rst_n) begin
      if (bus.flush_req) begin
        if (state == DIV_RUN) begin
          cancel    = 1'b1;
          state_nxt = IDLE;
        end
      end else begin
        case (state)
          IDLE: begin
            if (bus.exe_div_req) begin
              start     = 1'b1;
              stall_nxt = STALL_DIV;
              state_nxt = DIV_RUN;
            end else begin
              stall_nxt = id_stall(bus.stallreq_id);
            end
          end
          default: begin
            if (bus.div_ready) begin
              stall_nxt = id_stall(bus.stallreq_id);
              state_nxt = IDLE;
            end else if (div_cnt == DCNT_LAST) begin
              cancel      = 1'b1;
              timeout_hit = 1'b1;
              stall_nxt   = id_stall(bus.stallreq_id);
              state_nxt   = IDLE;
            end else begin
              stall_nxt = STALL_DIV;
              cnt_inc   = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state        <= IDLE;
      div_cnt      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        div_cnt <= '0;
      end else if (cnt_inc) begin
        div_cnt <= div_cnt + DCNT_W'(1);
      end
      if (timeout_hit) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  stall_ctrl_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (cpu_clk_50M),
    .rst_n (cpu_rst_n),
    .en    (stall_nxt != STALL_NONE),
    .count (bus.stall_cycles)
  );

  assign bus.stall       = STALL_W'(stall_nxt);
  assign bus.div_start   = start;
  assign bus.div_cancel  = cancel;
  assign bus.flush       = bus.flush_req & cpu_rst_n;
  assign bus.div_timeout = timeout_flag;

endmodule
